// File: rtl/dpr_arb_pkg.sv
// Shared definitions for the RAM port-A round-robin arbiter.
//   arb_state_t : controller state (zero sweep, then normal arbitration)
//   id_width()  : width of a requester index for a given requester count
package dpr_arb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    // Never returns zero, so a requester index always has at least one bit.
    function automatic int id_width(input int num_req);
        return (num_req <= 1) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/dpr_port_arbiter_rr_pick.sv
// Combinational rotating-priority picker.
//   req_valid  : per-requester request vector
//   ptr        : index of the last granted requester; the search starts at ptr+1
//   grant      : one-hot grant (all zero when nobody requests)
//   grant_idx  : index of the granted requester
//   any_grant  : high when some requester is granted
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = 2
)(
    input  logic [N-1:0]    req_valid,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            any_grant
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        // k runs to N so the previous winner is considered last, which lets a
        // lone requester win even when it holds the pointer.
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any_grant && req_valid[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/dpr_port_arbiter.sv
// Shares port A of a true dual-port RAM among NUM_REQ requesters.
// After reset every location is swept to zero; then one command per cycle is
// granted with rotating priority and read data is returned tagged with the
// issuing requester's index.
//   clk, rst              : clock, async active-high reset
//   req_valid/we/addr/din : per-requester commands (flattened, slice i = requester i)
//   req_ready             : one-hot grant, handshake = valid & ready at the edge
//   rsp_valid/id/rdata    : read response, rdata forced to 0 when not valid
//   init_done             : zero sweep finished
//   ram_en/we/addr/din    : registered RAM port A command
//   ram_dout              : RAM port A read data (one-cycle synchronous read)
module dpr_port_arbiter
    import dpr_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int ADDR_SIZE = 8,
    parameter  int DATA_SIZE = 8,
    parameter  int RAM_SIZE  = 1 << ADDR_SIZE,
    localparam int ID_W      = id_width(NUM_REQ)
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_SIZE-1:0]  req_din,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          rsp_valid,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_SIZE-1:0]          rsp_rdata,
    output logic                          init_done,
    output logic                          ram_en,
    output logic                          ram_we,
    output logic [ADDR_SIZE-1:0]          ram_addr,
    output logic [DATA_SIZE-1:0]          ram_din,
    input  logic [DATA_SIZE-1:0]          ram_dout
);

    localparam int CNT_W = ADDR_SIZE + 1;

    arb_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [ID_W-1:0]    ptr;
    logic               pend_v;
    logic [ID_W-1:0]    pend_id;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               any_grant;
    logic               sweep_end;
    logic               handshake;

    rr_pick #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // The extra counter bit lets cnt reach RAM_SIZE, so the cycle after the
    // last sweep command is distinguishable without wrapping to zero.
    assign sweep_end = (cnt == CNT_W'(RAM_SIZE));
    assign req_ready = (state == ST_RUN) ? grant : '0;
    assign handshake = (state == ST_RUN) && any_grant;
    assign rsp_rdata = rsp_valid ? ram_dout : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            cnt       <= '0;
            ptr       <= ID_W'(NUM_REQ - 1);
            init_done <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            pend_v    <= 1'b0;
            pend_id   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
        end else begin
            rsp_valid <= pend_v;
            rsp_id    <= pend_id;
            case (state)
                ST_INIT: begin
                    pend_v <= 1'b0;
                    if (sweep_end) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                        ram_en    <= 1'b0;
                        ram_we    <= 1'b0;
                    end else begin
                        ram_en   <= 1'b1;
                        ram_we   <= 1'b1;
                        ram_addr <= cnt[ADDR_SIZE-1:0];
                        ram_din  <= '0;
                        cnt      <= cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (handshake) begin
                        ptr      <= grant_idx;
                        ram_en   <= 1'b1;
                        ram_we   <= req_we[grant_idx];
                        ram_addr <= req_addr[int'(grant_idx)*ADDR_SIZE +: ADDR_SIZE];
                        ram_din  <= req_din[int'(grant_idx)*DATA_SIZE +: DATA_SIZE];
                        pend_v   <= ~req_we[grant_idx];
                        pend_id  <= grant_idx;
                    end else begin
                        ram_en <= 1'b0;
                        ram_we <= 1'b0;
                        pend_v <= 1'b0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_dpr_port_arbiter.sv
module tb_dpr_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_we = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_din = '0;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_rdata;
    logic        init_done;
    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout = '0;
    logic [7:0]  mem [256];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dpr_port_arbiter #(
        .NUM_REQ   (4),
        .ADDR_SIZE (8),
        .DATA_SIZE (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_din   (req_din),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // Port-A RAM model, read-first, one-cycle synchronous read.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [7:0] a, input logic [7:0] d);
        req_valid[i]       = v;
        req_we[i]          = we;
        req_addr[i*8 +: 8] = a;
        req_din[i*8 +: 8]  = d;
    endtask

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         seq [8];
        logic [7:0] rd_by_id [4];

        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;

        // Requester 0 already waits with a read of 0x10 during reset and sweep.
        set_req(0, 1'b1, 1'b0, 8'h10, 8'h00);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outputs", {ram_en, ram_we, ram_addr, ram_din, init_done, rsp_valid, rsp_rdata},
            32'h0);
        chk("rst_ready", req_ready, 4'b0000);

        rst = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            chk("sweep", {ram_en, ram_we, ram_addr, ram_din, req_ready, init_done},
                {1'b1, 1'b1, 8'(k - 1), 8'h00, 4'b0000, 1'b0});
        end
        @(negedge clk);                         // cycle 257
        chk("init_done", init_done, 1'b1);
        chk("init_en_low", ram_en, 1'b0);
        chk("first_grant", req_ready, 4'b0001);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 8'h10, 8'h00);
        chk("rd10_cmd", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, 8'h10});
        chk("rd10_no_rsp_yet", rsp_valid, 1'b0);
        @(negedge clk);
        chk("rd10_rsp", {rsp_valid, rsp_id, rsp_rdata}, {1'b1, 2'd0, 8'h00});
        @(negedge clk);
        chk("rd10_rsp_end", {rsp_valid, rsp_rdata}, {1'b0, 8'h00});

        // Req1 write then read of 0x01 (ptr = 0).
        set_req(1, 1'b1, 1'b1, 8'h01, 8'hA1);
        #1 chk("wr01_grant", req_ready, 4'b0010);
        @(negedge clk);
        chk("wr01_cmd", {ram_en, ram_we, ram_addr, ram_din}, {1'b1, 1'b1, 8'h01, 8'hA1});
        set_req(1, 1'b1, 1'b0, 8'h01, 8'h00);
        #1 chk("rd01_grant", req_ready, 4'b0010);
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 8'h01, 8'h00);
        chk("rd01_wait", rsp_valid, 1'b0);
        @(negedge clk);
        chk("rd01_rsp", {rsp_valid, rsp_id, rsp_rdata}, {1'b1, 2'd1, 8'hA1});

        // ptr = 1: req2 write 0x3C to 0x05 and req3 read 0x05 together.
        @(negedge clk);
        set_req(2, 1'b1, 1'b1, 8'h05, 8'h3C);
        set_req(3, 1'b1, 1'b0, 8'h05, 8'h00);
        #1 chk("pair_grant2", req_ready, 4'b0100);
        @(negedge clk);
        chk("pair_wr_cmd", {ram_en, ram_we, ram_addr, ram_din}, {1'b1, 1'b1, 8'h05, 8'h3C});
        set_req(2, 1'b0, 1'b0, 8'h05, 8'h00);
        #1 chk("pair_grant3", req_ready, 4'b1000);
        @(negedge clk);
        set_req(3, 1'b0, 1'b0, 8'h05, 8'h00);
        chk("pair_wait", rsp_valid, 1'b0);
        @(negedge clk);
        chk("pair_rsp", {rsp_valid, rsp_id, rsp_rdata}, {1'b1, 2'd3, 8'h3C});

        // ptr = 3, only req2 valid: granted in the same cycle.
        @(negedge clk);
        set_req(2, 1'b1, 1'b0, 8'h05, 8'h00);
        #1 chk("lone_grant", req_ready, 4'b0100);
        @(negedge clk);
        set_req(2, 1'b0, 1'b0, 8'h05, 8'h00);
        @(negedge clk);
        chk("lone_rsp", {rsp_valid, rsp_id, rsp_rdata}, {1'b1, 2'd2, 8'h3C});

        // All four hold reads for 8 cycles; ptr = 2 so rotation starts at 3.
        seq = '{3, 0, 1, 2, 3, 0, 1, 2};
        rd_by_id = '{8'hA1, 8'h3C, 8'h00, 8'hA1};
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 8'h01, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h05, 8'h00);
        set_req(2, 1'b0, 1'b0, 8'h10, 8'h00);
        set_req(3, 1'b0, 1'b0, 8'h01, 8'h00);
        for (int k = 0; k < 12; k++) begin
            if (k >= 2 && k < 10)
                chk("rr_rsp", {rsp_valid, rsp_id, rsp_rdata},
                    {1'b1, 2'(seq[k-2]), rd_by_id[seq[k-2]]});
            else
                chk("rr_rsp_idle", {rsp_valid, rsp_rdata}, 9'h0);
            req_valid = (k < 8) ? 4'hF : 4'h0;
            if (k < 8) begin
                #1 chk("rr_grant", req_ready, onehot(seq[k]));
            end
            @(negedge clk);
        end

        // Reset with one read outstanding.
        set_req(0, 1'b1, 1'b0, 8'h01, 8'h00);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 8'h01, 8'h00);
        chk("midrst_pending", ram_en, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_now", {rsp_valid, init_done, ram_en, ram_addr, req_ready}, 32'h0);
        @(negedge clk);
        chk("midrst_hold", {rsp_valid, rsp_rdata, init_done}, 32'h0);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("resweep", {ram_en, ram_we, ram_addr, rsp_valid, init_done},
                {1'b1, 1'b1, 8'(k - 1), 1'b0, 1'b0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
